layer_buffer_ctrl: RTL

- Sequencer for the dual-port layer buffer BRAM (1-cycle registered read latency, read port always enabled).
- Captures a burst of PE result words into the buffer, then drains it to the next layer's consumer one or more times, with valid/ready backpressure and full throughput.
- Drives the buffer's write enable, write address and read address.
- Sits between the PE array outputs and the next-layer input feeder.

---
 rtl/layer_buffer_ctrl_if.sv | 29 ++
 rtl/layer_buffer_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/layer_buffer_ctrl_if.sv
// Handshake and buffer-address bundle between the layer buffer sequencer,
// the PE array side and the next-layer consumer.
interface layer_buffer_ctrl_if #(
  parameter int AWIDTH = 8,
  parameter int PWIDTH = 4
);
  logic              start;
  logic              abort;
  logic [AWIDTH:0]   wr_len;
  logic [PWIDTH-1:0] rd_passes;
  logic              pe_valid;
  logic              din_st;
  logic [AWIDTH-1:0] layer_buffer_waddr;
  logic [AWIDTH-1:0] layer_buffer_raddr;
  logic              dout_valid;
  logic              rd_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, wr_len, rd_passes, pe_valid, rd_ready,
    input  din_st, layer_buffer_waddr, layer_buffer_raddr, dout_valid, busy, done
  );

  modport slave (
    input  start, abort, wr_len, rd_passes, pe_valid, rd_ready,
    output din_st, layer_buffer_waddr, layer_buffer_raddr, dout_valid, busy, done
  );
endinterface

// File: rtl/layer_buffer_ctrl.sv
// Layer buffer sequencer: captures a burst of PE results into the BRAM, then
// streams it out one or more times with valid/ready and no bubbles.
module layer_buffer_ctrl #(
  parameter int AWIDTH = 8,
  parameter int PWIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  layer_buffer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  localparam logic [AWIDTH:0]   LONE = 1;
  localparam logic [AWIDTH-1:0] AONE = 1;
  localparam logic [PWIDTH-1:0] PONE = 1;

  state_t            state_q, state_d;
  logic [AWIDTH:0]   len_q, len_d;
  logic [PWIDTH-1:0] passes_q, passes_d;
  logic [AWIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic [AWIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [PWIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic              dout_valid_q, dout_valid_d;

  logic              din_st;
  logic [AWIDTH-1:0] waddr;
  logic [AWIDTH-1:0] raddr;
  logic              xfer;
  logic              lastIdx;
  logic [AWIDTH-1:0] nextIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      passes_q     <= '0;
      wr_cnt_q     <= '0;
      rd_idx_q     <= '0;
      pass_cnt_q   <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      passes_q     <= passes_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_idx_q     <= rd_idx_d;
      pass_cnt_q   <= pass_cnt_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign xfer    = dout_valid_q && bus.rd_ready;
  assign lastIdx = ({1'b0, rd_idx_q} == (len_q - LONE));
  assign nextIdx = lastIdx ? '0 : (rd_idx_q + AONE);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    passes_d     = passes_q;
    wr_cnt_d     = wr_cnt_q;
    rd_idx_d     = rd_idx_q;
    pass_cnt_d   = pass_cnt_q;
    dout_valid_d = 1'b0;
    din_st       = 1'b0;
    waddr        = '0;
    raddr        = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d      = bus.wr_len;
          passes_d   = (bus.rd_passes == '0) ? PONE : bus.rd_passes;
          wr_cnt_d   = '0;
          rd_idx_d   = '0;
          pass_cnt_d = '0;
          state_d    = (bus.wr_len != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        din_st = bus.pe_valid;
        waddr  = wr_cnt_q[AWIDTH-1:0];
        if (bus.pe_valid) begin
          wr_cnt_d = wr_cnt_q + LONE;
          if (wr_cnt_q == (len_q - LONE)) begin
            state_d  = DRAIN;
            rd_idx_d = '0;
          end
        end
      end
      DRAIN: begin
        // The priming cycle reads word 0 so its data is ready when valid rises;
        // afterwards raddr looks one word ahead on every transfer.
        if (!dout_valid_q) begin
          raddr        = '0;
          dout_valid_d = 1'b1;
        end else begin
          raddr        = xfer ? nextIdx : rd_idx_q;
          dout_valid_d = 1'b1;
          if (xfer) begin
            rd_idx_d = nextIdx;
            if (lastIdx) begin
              pass_cnt_d = pass_cnt_q + PONE;
              if ((pass_cnt_q + PONE) == passes_q) begin
                state_d      = DONE;
                dout_valid_d = 1'b0;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      wr_cnt_d     = '0;
      rd_idx_d     = '0;
      pass_cnt_d   = '0;
      dout_valid_d = 1'b0;
    end
  end

  assign bus.din_st             = din_st;
  assign bus.layer_buffer_waddr = waddr;
  assign bus.layer_buffer_raddr = raddr;
  assign bus.dout_valid         = dout_valid_q;
  assign bus.busy               = (state_q != IDLE);
  assign bus.done               = (state_q == DONE);

endmodule
